resp_trans_engine: RTL

// Multi-channel responder transmit engine, successor to the single-thread responder TX core. Round-robin arbitrates NUM_CH

---
 rtl/resp_trans_engine.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/resp_trans_engine.sv
// Multi-channel responder TX engine: round-robin picks a response queue, gathers its payload into the
// packet buffer in PMTU-sized packets and emits one egress header per packet; every interface stalls in place.
module resp_trans_engine #(
    parameter int NUM_CH   = 2,
    parameter int CH_W     = 1,
    parameter int META_W   = 128,
    parameter int LEN_W    = 16,
    parameter int DATA_W   = 512,
    parameter int SLOT_LOG = 14,
    parameter int PMTU     = 4096
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_CH-1:0]                      net_resp_empty,
    input  logic [NUM_CH*META_W-1:0]               net_resp_dout,
    output logic [NUM_CH-1:0]                      net_resp_ren,
    input  logic [NUM_CH-1:0]                      payload_empty,
    input  logic [NUM_CH*DATA_W-1:0]               payload_data,
    output logic [NUM_CH-1:0]                      payload_ren,
    output logic                                   insert_req_valid,
    output logic                                   insert_req_start,
    output logic                                   insert_req_last,
    output logic [SLOT_LOG-1:0]                    insert_req_head,
    output logic [DATA_W-1:0]                      insert_req_data,
    input  logic                                   insert_req_ready,
    input  logic                                   insert_resp_valid,
    input  logic [SLOT_LOG-1:0]                    insert_resp_data,
    output logic                                   egress_pkt_valid,
    output logic [META_W+SLOT_LOG+LEN_W+CH_W+2:0]  egress_pkt_head,
    input  logic                                   egress_pkt_ready
);
    localparam int BPB = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_SEG, S_INS_START, S_WAIT_HEAD, S_INS_BODY, S_EMIT
    } state_t;

    state_t                   r_state;
    logic [CH_W-1:0]          r_ch;
    logic [CH_W-1:0]          r_rr_ptr;
    logic [META_W-1:LEN_W]    r_meta_hi;
    logic [LEN_W-1:0]         r_rem;
    logic [LEN_W-1:0]         r_pkt_len;
    logic [LEN_W-1:0]         r_beats;
    logic [LEN_W-1:0]         r_beat_cnt;
    logic [SLOT_LOG-1:0]      r_slot;
    logic                     r_first;
    logic                     r_has_pld;

    logic [CH_W-1:0]          w_pick;
    logic                     w_any;
    int                       w_best;
    int                       w_dist;
    logic [META_W-1:0]        w_meta;
    logic [DATA_W-1:0]        w_pdat;
    logic                     w_pempty;
    logic [LEN_W-1:0]         w_seg_len;
    logic [LEN_W-1:0]         w_seg_beats;
    logic                     w_ins;
    logic                     w_fire;
    logic                     w_last_pkt;

    // Nearest non-empty channel at or after the round-robin pointer wins.
    always_comb begin
        w_pick = r_rr_ptr;
        w_best = NUM_CH;
        w_dist = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!net_resp_empty[c]) begin
                w_dist = (c + NUM_CH - int'(r_rr_ptr)) % NUM_CH;
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    w_pick = CH_W'(c);
                end
            end
        end
        w_any = (w_best < NUM_CH);
    end

    always_comb begin
        w_meta   = '0;
        w_pdat   = '0;
        w_pempty = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_meta   = net_resp_dout[c*META_W +: META_W];
                w_pdat   = payload_data[c*DATA_W +: DATA_W];
                w_pempty = payload_empty[c];
            end
        end
    end

    assign w_seg_len   = (r_rem > LEN_W'(PMTU)) ? LEN_W'(PMTU) : r_rem;
    assign w_seg_beats = LEN_W'((int'(w_seg_len) + BPB - 1) / BPB);
    assign w_ins       = (r_state == S_INS_START) || (r_state == S_INS_BODY);
    assign w_last_pkt  = (r_rem == r_pkt_len);

    assign insert_req_valid = w_ins && !w_pempty;
    assign insert_req_start = (r_state == S_INS_START);
    assign insert_req_last  = ((r_state == S_INS_START) && (r_beats == LEN_W'(1))) ||
                              ((r_state == S_INS_BODY) && (r_beat_cnt == r_beats - LEN_W'(1)));
    assign insert_req_head  = (r_state == S_INS_BODY) ? r_slot : '0;
    assign insert_req_data  = w_ins ? w_pdat : '0;
    assign w_fire           = insert_req_valid && insert_req_ready;

    always_comb begin
        net_resp_ren = '0;
        payload_ren  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == CH_W'(c)) begin
                net_resp_ren[c] = (r_state == S_GRANT);
                payload_ren[c]  = w_fire;
            end
        end
    end

    assign egress_pkt_valid = (r_state == S_EMIT);
    assign egress_pkt_head  = (r_state == S_EMIT) ?
        {w_last_pkt, r_first, r_has_pld, r_ch, r_slot, r_pkt_len, r_meta_hi, {LEN_W{1'b0}}} : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_rr_ptr   <= '0;
            r_meta_hi  <= '0;
            r_rem      <= '0;
            r_pkt_len  <= '0;
            r_beats    <= '0;
            r_beat_cnt <= '0;
            r_slot     <= '0;
            r_first    <= 1'b0;
            r_has_pld  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ch    <= w_pick;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_meta_hi <= w_meta[META_W-1:LEN_W];
                    r_rem     <= w_meta[LEN_W-1:0];
                    r_first   <= 1'b1;
                    r_state   <= S_SEG;
                end
                S_SEG: begin
                    r_pkt_len  <= w_seg_len;
                    r_beats    <= w_seg_beats;
                    r_beat_cnt <= '0;
                    r_slot     <= '0;
                    r_has_pld  <= (w_seg_len != '0);
                    r_state    <= (w_seg_len == '0) ? S_EMIT : S_INS_START;
                end
                S_INS_START: begin
                    if (w_fire) begin
                        r_beat_cnt <= LEN_W'(1);
                        r_state    <= S_WAIT_HEAD;
                    end
                end
                S_WAIT_HEAD: begin
                    if (insert_resp_valid) begin
                        r_slot  <= insert_resp_data;
                        r_state <= (r_beats == LEN_W'(1)) ? S_EMIT : S_INS_BODY;
                    end
                end
                S_INS_BODY: begin
                    if (w_fire) begin
                        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                        if (insert_req_last) r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (egress_pkt_ready) begin
                        r_rem   <= r_rem - r_pkt_len;
                        r_first <= 1'b0;
                        if (w_last_pkt) begin
                            r_rr_ptr <= CH_W'((int'(r_ch) + 1) % NUM_CH);
                            r_state  <= S_IDLE;
                        end else begin
                            r_state  <= S_SEG;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
